// File: rtl/bus_serial_port.sv
// rtl/bus_serial_port.sv - memory-mapped 8N1 serial port with TX FIFO and RX holding register
module bus_serial_port #(
  parameter logic [7:0]  BASE         = 8'h00,
  parameter logic [15:0] CLKS_PER_BIT = 16'd16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset_bar,
  inout  wire  [15:0] bus,
  input  logic [15:0] addr,
  input  logic        DI,
  input  logic        DO,
  input  logic        rxd,
  output logic        txd,
  output logic        irq
);

  localparam int          PW      = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  // ---------------------------------------------------------------- decode
  logic [7:0]  reg_off;
  logic        sel, wr_en, rd_en;
  logic        wr_data, wr_status, wr_div, rd_data;
  logic [15:0] rdata;
  logic        unused_addr_hi;

  assign reg_off        = addr[7:0] - BASE;
  assign sel            = (reg_off < 8'd3);
  // A write strobe wins over a simultaneous read strobe.
  assign wr_en          = sel & DI;
  assign rd_en          = sel & DO & ~DI;
  assign wr_data        = wr_en & (reg_off == 8'd0);
  assign wr_status      = wr_en & (reg_off == 8'd1);
  assign wr_div         = wr_en & (reg_off == 8'd2);
  assign rd_data        = rd_en & (reg_off == 8'd0);
  assign unused_addr_hi = ^addr[15:8];

  assign bus = rd_en ? rdata : 16'hzzzz;

  // ------------------------------------------------------------- TX FIFO
  logic [7:0]  fifo_mem_q [FIFO_DEPTH];
  logic [7:0]  fifo_mem_d [FIFO_DEPTH];
  logic [PW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic        fifo_empty, fifo_full, fifo_push, tx_pop;
  logic [7:0]  fifo_head;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign fifo_push  = wr_data & ~fifo_full;
  assign fifo_head  = fifo_mem_q[rptr_q[PW-1:0]];

  // FIFO storage and pointer updates; push and pop may coincide
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    if (fifo_push) begin
      fifo_mem_d[wptr_q[PW-1:0]] = bus[7:0];
      wptr_d                     = wptr_q + PTR_ONE;
    end
    if (tx_pop) begin
      rptr_d = rptr_q + PTR_ONE;
    end
  end

  // FIFO state registers
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= 8'h00;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      fifo_mem_q <= fifo_mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  // ------------------------------------------------------------ TX engine
  tx_state_t   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        txd_q, txd_d;
  logic        tx_last, tx_busy;
  logic [15:0] div_q, div_d;

  assign tx_last = (tx_cnt_q == tx_div_q - 16'd1);
  assign tx_busy = (tx_state_q != TX_IDLE);

  // TX next state; txd is registered from the current state, so the line
  // lags the state by one clock and back-to-back frames stay gap-free
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    txd_d      = 1'b1;
    case (tx_state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = fifo_head;
          tx_div_d   = div_q;
          tx_cnt_d   = 16'd0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        txd_d = 1'b0;
        if (tx_last) begin
          tx_cnt_d   = 16'd0;
          tx_bit_d   = 3'd0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      TX_DATA: begin
        txd_d = tx_shift_q[0];
        if (tx_last) begin
          tx_cnt_d   = 16'd0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      TX_STOP: begin
        txd_d = 1'b1;
        if (tx_last) begin
          tx_cnt_d = 16'd0;
          if (!fifo_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = fifo_head;
            tx_div_d   = div_q;
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX state registers
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= 16'd0;
      tx_div_q   <= CLKS_PER_BIT;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  assign txd = txd_q;

  // ------------------------------------------------------------ RX engine
  rx_state_t   rx_state_q, rx_state_d;
  logic        rx_sync1_q, rx_sync2_q, rx_prev_q;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_fall, rx_store, rx_frame_bad;

  assign rx_fall = rx_prev_q & ~rx_sync2_q;

  // RX next state: start check at half a bit, then one sample per bit time
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_div_d     = rx_div_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_store     = 1'b0;
    rx_frame_bad = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_cnt_d   = 16'd0;
          rx_div_d   = div_q;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == (rx_div_q >> 1) - 16'd1) begin
          rx_cnt_d = 16'd0;
          rx_bit_d = 3'd0;
          // Line back high at mid start bit: treat as a glitch.
          rx_state_d = rx_sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == rx_div_q - 16'd1) begin
          rx_cnt_d   = 16'd0;
          rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == rx_div_q - 16'd1) begin
          rx_cnt_d = 16'd0;
          if (rx_sync2_q) begin
            rx_store   = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_frame_bad = 1'b1;
            rx_state_d   = RX_BREAK;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RX_BREAK: begin
        if (rx_sync2_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX state registers and input synchronizer
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      rx_state_q <= RX_IDLE;
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_cnt_q   <= 16'd0;
      rx_div_q   <= CLKS_PER_BIT;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
    end else begin
      rx_state_q <= rx_state_d;
      rx_sync1_q <= rxd;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // ------------------------------------------------- CPU-visible registers
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_ovr_q, rx_ovr_d, tx_ovr_q, tx_ovr_d, frame_err_q, frame_err_d;

  // Register updates; hardware set events take priority over software clears
  always_comb begin
    div_d       = div_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    rx_ovr_d    = rx_ovr_q;
    tx_ovr_d    = tx_ovr_q;
    frame_err_d = frame_err_q;
    if (wr_div) div_d = (bus < 16'd2) ? 16'd2 : bus;
    if (wr_status) begin
      rx_ovr_d    = 1'b0;
      tx_ovr_d    = 1'b0;
      frame_err_d = 1'b0;
    end
    if (rd_data) rx_valid_d = 1'b0;
    if (rx_store) begin
      rx_data_d  = rx_shift_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q) rx_ovr_d = 1'b1;
    end
    if (rx_frame_bad) frame_err_d = 1'b1;
    if (wr_data && fifo_full) tx_ovr_d = 1'b1;
  end

  // Register file flops
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      div_q       <= CLKS_PER_BIT;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      rx_ovr_q    <= 1'b0;
      tx_ovr_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_ovr_q    <= rx_ovr_d;
      tx_ovr_q    <= tx_ovr_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Read data mux
  always_comb begin
    rdata = 16'h0000;
    case (reg_off)
      8'd0:    rdata = {8'h00, rx_data_q};
      8'd1:    rdata = {9'd0, frame_err_q, tx_ovr_q, rx_ovr_q, tx_busy,
                        fifo_empty, fifo_full, rx_valid_q};
      8'd2:    rdata = div_q;
      default: rdata = 16'h0000;
    endcase
  end

  assign irq = rx_valid_q | fifo_empty;

endmodule

// File: tb/tb_bus_serial_port.sv
// tb/tb_bus_serial_port.sv - scoreboard bench for bus_serial_port
module tb_bus_serial_port;

  localparam logic [7:0] BASE = 8'h00;

  logic        clk = 1'b0;
  logic        reset_bar;
  tri1  [15:0] bus;
  logic [15:0] bus_drv;
  logic        bus_oe;
  logic [15:0] addr;
  logic        DI, DO, rxd;
  wire         txd, irq;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  assign bus = bus_oe ? bus_drv : 16'hzzzz;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus_serial_port #(.BASE(BASE), .CLKS_PER_BIT(16'd16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_bar(reset_bar), .bus(bus), .addr(addr),
    .DI(DI), .DO(DO), .rxd(rxd), .txd(txd), .irq(irq)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  // All bus tasks are entered on a falling edge and return on one.
  task automatic bus_write(input logic [7:0] off, input logic [15:0] val);
    addr    = {8'h00, BASE + off};
    bus_drv = val;
    bus_oe  = 1'b1;
    DI      = 1'b1;
    @(negedge clk);
    DI     = 1'b0;
    bus_oe = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] off, output logic [15:0] val);
    addr = {8'h00, BASE + off};
    DO   = 1'b1;
    #1 val = bus;
    @(negedge clk);
    DO = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] data, input logic stop_bit, input int div);
    rxd = 1'b0;
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      repeat (div) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (div) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * div) @(negedge clk);
  endtask

  // Decodes n frames off txd, checking each against the TX scoreboard and
  // that consecutive start bits are exactly one frame apart.
  task automatic collect_tx(input int n, input int div);
    int         t, start, last_start;
    logic [7:0] got, exp;
    logic       stop_v;
    last_start = 0;
    for (int f = 0; f < n; f++) begin
      t = 0;
      while (txd !== 1'b0 && t < 400) begin
        @(negedge clk);
        t++;
      end
      checks++;
      if (txd !== 1'b0) begin
        errors++;
        $display("FAIL tx_start_timeout frame %0d txd=%b expected 0", f, txd);
        return;
      end
      start = cyc;
      if (f > 0) begin
        checks++;
        if (start - last_start != 10 * div) begin
          errors++;
          $display("FAIL tx_frame_gap frame %0d period=%0d expected %0d", f, start - last_start, 10 * div);
        end
      end
      last_start = start;
      repeat (div / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (div) @(negedge clk);
        got[i] = txd;
      end
      repeat (div) @(negedge clk);
      stop_v = txd;
      checks++;
      if (tx_exp.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected_frame got=%h expected none", got);
      end else begin
        exp = tx_exp.pop_front();
        if (got !== exp || stop_v !== 1'b1) begin
          errors++;
          $display("FAIL tx_frame got=%h stop=%b expected %h stop=1", got, stop_v, exp);
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [15:0] v;
    reset_bar = 1'b0; DI = 1'b0; DO = 1'b0; bus_oe = 1'b0; bus_drv = 16'h0000;
    addr = 16'h0000; rxd = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (txd !== 1'b1 || irq !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs got txd=%b irq=%b expected 1 1", txd, irq);
    end
    reset_bar = 1'b1;
    @(negedge clk);
    bus_read(8'd1, v);
    checks++;
    if (v !== 16'h0004) begin errors++; $display("FAIL reset_status got=%h expected 0004", v); end
    bus_read(8'd2, v);
    checks++;
    if (v !== 16'h0010) begin errors++; $display("FAIL reset_div got=%h expected 0010", v); end
    addr = {8'h00, BASE + 8'd1};
    #1;
    checks++;
    if (bus !== 16'hffff) begin errors++; $display("FAIL idle_bus_released got=%h expected ffff", bus); end
    @(negedge clk);
  endtask

  task automatic test_div_and_decode();
    logic [15:0] v;
    bus_write(8'd2, 16'h0001);
    bus_read(8'd2, v);
    checks++;
    if (v !== 16'h0002) begin errors++; $display("FAIL div_write_1 got=%h expected 0002", v); end
    bus_write(8'd2, 16'h0000);
    bus_read(8'd2, v);
    checks++;
    if (v !== 16'h0002) begin errors++; $display("FAIL div_write_0 got=%h expected 0002", v); end
    // Both strobes: the write happens.
    addr = {8'h00, BASE + 8'd2}; bus_drv = 16'h0123; bus_oe = 1'b1; DI = 1'b1; DO = 1'b1;
    @(negedge clk);
    DI = 1'b0; DO = 1'b0; bus_oe = 1'b0;
    bus_read(8'd2, v);
    checks++;
    if (v !== 16'h0123) begin errors++; $display("FAIL div_both_strobes got=%h expected 0123", v); end
    bus_read(8'd3, v);
    checks++;
    if (v !== 16'hffff) begin errors++; $display("FAIL unselected_read got=%h expected ffff", v); end
  endtask

  task automatic test_tx_single();
    logic [15:0] v;
    int          t;
    bus_write(8'd2, 16'd4);
    tx_exp.push_back(8'hA5);
    bus_write(8'd0, 16'h01A5);
    t = 0;
    while (txd !== 1'b0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t != 2) begin errors++; $display("FAIL tx_latency got=%0d expected 2", t); end
    collect_tx(1, 4);
    t = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) t++;
    end
    checks++;
    if (t != 0) begin errors++; $display("FAIL tx_idle_after_frame low_cycles=%0d expected 0", t); end
    bus_read(8'd1, v);
    checks++;
    if (v !== 16'h0004) begin errors++; $display("FAIL tx_done_status got=%h expected 0004", v); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    tx_exp.push_back(8'h10);
    fork
      collect_tx(5, 4);
      begin
        bus_write(8'd0, 16'h0010);
        repeat (3) @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
          tx_exp.push_back(8'h20 + 8'(i));
          bus_write(8'd0, 16'h0020 + 16'(i));
        end
        bus_read(8'd1, v);
        checks++;
        if (v !== 16'h000A) begin errors++; $display("FAIL fifo_full_status got=%h expected 000a", v); end
        bus_write(8'd0, 16'h0025);
        bus_read(8'd1, v);
        checks++;
        if (v !== 16'h002A) begin errors++; $display("FAIL tx_overrun_status got=%h expected 002a", v); end
        bus_write(8'd1, 16'hFFFF);
        bus_read(8'd1, v);
        checks++;
        if (v !== 16'h000A) begin errors++; $display("FAIL tx_overrun_clear got=%h expected 000a", v); end
      end
    join
    repeat (10) @(negedge clk);
    checks++;
    if (tx_exp.size() != 0) begin errors++; $display("FAIL tx_scoreboard_left got=%0d expected 0", tx_exp.size()); end
    bus_read(8'd1, v);
    checks++;
    if (v !== 16'h0004) begin errors++; $display("FAIL tx_drained_status got=%h expected 0004", v); end
  endtask

  task automatic test_rx_basic();
    logic [15:0] v, exp;
    bus_write(8'd2, 16'd8);
    rx_exp.push_back(8'h3C);
    send_rx(8'h3C, 1'b1, 8);
    bus_read(8'd1, v);
    checks++;
    if (v !== 16'h0005 || irq !== 1'b1) begin
      errors++;
      $display("FAIL rx_valid_status got=%h irq=%b expected 0005 irq=1", v, irq);
    end
    exp = {8'h00, rx_exp.pop_front()};
    bus_read(8'd0, v);
    checks++;
    if (v !== exp) begin errors++; $display("FAIL rx_data got=%h expected %h", v, exp); end
    bus_read(8'd1, v);
    checks++;
    if (v !== 16'h0004) begin errors++; $display("FAIL rx_valid_clear got=%h expected 0004", v); end
    bus_read(8'd0, v);
    checks++;
    if (v !== exp) begin errors++; $display("FAIL rx_stale_read got=%h expected %h", v, exp); end
  endtask

  task automatic test_rx_errors();
    logic [15:0] v, exp;
    rx_exp.push_back(8'h11);
    send_rx(8'h11, 1'b1, 8);
    rx_exp.push_back(8'h22);
    send_rx(8'h22, 1'b1, 8);
    bus_read(8'd1, v);
    checks++;
    if (v !== 16'h0015) begin errors++; $display("FAIL rx_overrun_status got=%h expected 0015", v); end
    exp = {8'h00, rx_exp[$]};
    rx_exp.delete();
    bus_read(8'd0, v);
    checks++;
    if (v !== exp) begin errors++; $display("FAIL rx_overrun_data got=%h expected %h", v, exp); end
    send_rx(8'h55, 1'b0, 8);
    bus_read(8'd1, v);
    checks++;
    if (v !== 16'h0054) begin errors++; $display("FAIL framing_status got=%h expected 0054", v); end
    bus_read(8'd0, v);
    checks++;
    if (v !== exp) begin errors++; $display("FAIL framing_data_kept got=%h expected %h", v, exp); end
    bus_write(8'd1, 16'h0000);
    bus_read(8'd1, v);
    checks++;
    if (v !== 16'h0004) begin errors++; $display("FAIL error_clear got=%h expected 0004", v); end
  endtask

  task automatic test_glitch();
    logic [15:0] v, exp;
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (100) @(negedge clk);
    bus_read(8'd1, v);
    checks++;
    if (v !== 16'h0004) begin errors++; $display("FAIL glitch_rejected got=%h expected 0004", v); end
    rx_exp.push_back(8'h5A);
    send_rx(8'h5A, 1'b1, 8);
    exp = {8'h00, rx_exp.pop_front()};
    bus_read(8'd0, v);
    checks++;
    if (v !== exp) begin errors++; $display("FAIL rx_after_glitch got=%h expected %h", v, exp); end
  endtask

  task automatic test_reset_mid_tx();
    logic [15:0] v;
    int          t;
    bus_write(8'd2, 16'd4);
    bus_write(8'd0, 16'h0000);
    bus_write(8'd0, 16'h0000);
    bus_write(8'd0, 16'h0000);
    repeat (12) @(negedge clk);
    checks++;
    if (txd !== 1'b0) begin errors++; $display("FAIL tx_mid_frame_low got=%b expected 0", txd); end
    reset_bar = 1'b0;
    #1;
    checks++;
    if (txd !== 1'b1 || irq !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_outputs got txd=%b irq=%b expected 1 1", txd, irq);
    end
    @(negedge clk);
    reset_bar = 1'b1;
    tx_exp.delete();
    @(negedge clk);
    bus_read(8'd1, v);
    checks++;
    if (v !== 16'h0004) begin errors++; $display("FAIL post_reset_status got=%h expected 0004", v); end
    bus_read(8'd2, v);
    checks++;
    if (v !== 16'h0010) begin errors++; $display("FAIL post_reset_div got=%h expected 0010", v); end
    t = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) t++;
    end
    checks++;
    if (t != 0) begin errors++; $display("FAIL post_reset_txd_idle low_cycles=%0d expected 0", t); end
  endtask

  initial begin
    test_reset();
    test_div_and_decode();
    test_tx_single();
    test_back_to_back();
    test_rx_basic();
    test_rx_errors();
    test_glitch();
    test_reset_mid_tx();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
